// File: rtl/dsm_dac_multi_pkg.sv
// Shared definitions for the multi-channel delta-sigma DAC: counter widths,
// the midscale helper and the modulator control/selection types.
package dsm_dac_multi_pkg;

  localparam int UNDERRUN_CNT_W = 8;
  localparam logic [UNDERRUN_CNT_W-1:0] UNDERRUN_CNT_MAX = '1;

  typedef enum logic {
    ORDER_1 = 1'b0,
    ORDER_2 = 1'b1
  } mod_order_e;

  // Strobes shared by every channel modulator.
  typedef struct packed {
    logic tick;
    logic clr;
  } mod_strobe_t;

  function automatic int midscale(input int width);
    return 1 << (width - 1);
  endfunction

endpackage

// File: rtl/dsm_dac_mod.sv
// One-channel PDM modulator: first-order accumulator, plus an optional
// second-order error-feedback path when DSM_DAC_ORDER2_EN is defined.
module dsm_dac_mod
  import dsm_dac_multi_pkg::*;
#(
  parameter int BIT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  mod_strobe_t          strobe,
  input  logic                 mute,
`ifdef DSM_DAC_ORDER2_EN
  input  mod_order_e           order,
`endif
  input  logic [BIT_WIDTH-1:0] sample,
  output logic                 dac_bit
);
  localparam logic [BIT_WIDTH-1:0] MID = BIT_WIDTH'(midscale(BIT_WIDTH));

  logic [BIT_WIDTH-1:0] u;
  logic [BIT_WIDTH-1:0] acc;
  logic [BIT_WIDTH:0]   sum1;

  // Offset-binary modulator input; mute forces exact midscale.
  assign u    = mute ? MID : {~sample[BIT_WIDTH-1], sample[BIT_WIDTH-2:0]};
  assign sum1 = {1'b0, acc} + {1'b0, u};

`ifdef DSM_DAC_ORDER2_EN
  localparam int SW = BIT_WIDTH + 3;
  localparam int VW = BIT_WIDTH + 5;
  localparam logic signed [VW-1:0] V_MAX = VW'(2 ** (BIT_WIDTH + 1));
  localparam logic signed [VW-1:0] V_MIN = -V_MAX;
  localparam logic signed [VW-1:0] V_THR = VW'(2 ** (BIT_WIDTH - 1));
  localparam logic signed [VW-1:0] V_ONE = VW'(2 ** BIT_WIDTH);

  logic signed [SW-1:0] e1, e2, e_next;
  logic signed [VW-1:0] u_x, e1_x, e2_x, v_raw, v_sat, e_full;
  logic                 y;

  always_comb begin
    u_x    = $signed({{(VW-BIT_WIDTH){1'b0}}, u});
    e1_x   = $signed({{(VW-SW){e1[SW-1]}}, e1});
    e2_x   = $signed({{(VW-SW){e2[SW-1]}}, e2});
    v_raw  = u_x + (e1_x <<< 1) - e2_x;
    v_sat  = v_raw;
    if (v_raw > V_MAX) v_sat = V_MAX;
    else if (v_raw < V_MIN) v_sat = V_MIN;
    y      = (v_sat >= V_THR);
    e_full = y ? (v_sat - V_ONE) : v_sat;
    e_next = $signed(e_full[SW-1:0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      e1      <= '0;
      e2      <= '0;
      dac_bit <= 1'b0;
    end else if (strobe.tick) begin
      if (strobe.clr) begin
        acc     <= '0;
        e1      <= '0;
        e2      <= '0;
        dac_bit <= 1'b0;
      end else if (order == ORDER_2) begin
        dac_bit <= y;
        e2      <= e1;
        e1      <= e_next;
      end else begin
        dac_bit <= sum1[BIT_WIDTH];
        acc     <= sum1[BIT_WIDTH-1:0];
      end
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      dac_bit <= 1'b0;
    end else if (strobe.tick) begin
      if (strobe.clr) begin
        acc     <= '0;
        dac_bit <= 1'b0;
      end else begin
        dac_bit <= sum1[BIT_WIDTH];
        acc     <= sum1[BIT_WIDTH-1:0];
      end
    end
  end
`endif

endmodule

// File: rtl/dsm_dac_multi.sv
// Multi-channel delta-sigma DAC: tick divider, OSR framing, hold/active sample
// buffering with underrun tracking. DSM_DAC_ORDER2_EN enables the order2 path.
module dsm_dac_multi
  import dsm_dac_multi_pkg::*;
#(
  parameter int CH_NUM    = 2,
  parameter int BIT_WIDTH = 10,
  parameter int FREQ_DIV  = 5,
  parameter int OSR       = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [CH_NUM*BIT_WIDTH-1:0] s_data,
  input  logic                        mute,
  input  logic                        order2,
  output logic [CH_NUM-1:0]           dac_out,
  output logic                        underrun,
  output logic [UNDERRUN_CNT_W-1:0]   underrun_cnt
);
  localparam int DW    = CH_NUM * BIT_WIDTH;
  localparam int DIV_W = (FREQ_DIV > 1) ? $clog2(FREQ_DIV) : 1;
  localparam int OSR_W = $clog2(OSR);

  logic [DIV_W-1:0] div_cnt;
  logic [OSR_W-1:0] osr_cnt;
  logic             tick, boundary, hold_full, accept, mod_clr;
  logic [DW-1:0]    hold_data, active_data;
  mod_strobe_t      strobe;

  assign tick     = (div_cnt == DIV_W'(FREQ_DIV - 1));
  assign boundary = tick && (osr_cnt == OSR_W'(OSR - 1));
  assign s_ready  = !hold_full || boundary;
  assign accept   = s_valid && s_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      osr_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) osr_cnt <= boundary ? '0 : osr_cnt + OSR_W'(1);
    end
  end

  // A boundary promotes the held frame; without one, the active frame repeats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data    <= '0;
      active_data  <= '0;
      hold_full    <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (accept) hold_data <= s_data;
      if (boundary && hold_full) active_data <= hold_data;
      if (accept) hold_full <= 1'b1;
      else if (boundary) hold_full <= 1'b0;
      underrun <= boundary && !hold_full;
      if (boundary && !hold_full && underrun_cnt != UNDERRUN_CNT_MAX)
        underrun_cnt <= underrun_cnt + UNDERRUN_CNT_W'(1);
    end
  end

`ifdef DSM_DAC_ORDER2_EN
  mod_order_e order_reg;

  // Order changes land only on a sample boundary and restart both modulators.
  assign mod_clr = boundary && (order_reg != mod_order_e'(order2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) order_reg <= ORDER_1;
    else if (boundary) order_reg <= mod_order_e'(order2);
  end
`else
  logic unused_order2;
  assign unused_order2 = order2;
  assign mod_clr       = 1'b0;
`endif

  assign strobe.tick = tick;
  assign strobe.clr  = mod_clr;

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    dsm_dac_mod #(.BIT_WIDTH(BIT_WIDTH)) u_mod (
      .clk     (clk),
      .reset   (reset),
      .strobe  (strobe),
      .mute    (mute),
`ifdef DSM_DAC_ORDER2_EN
      .order   (order_reg),
`endif
      .sample  (active_data[gi*BIT_WIDTH +: BIT_WIDTH]),
      .dac_bit (dac_out[gi])
    );
  end

endmodule

// File: tb/tb_dsm_dac_multi.sv
// Directed + randomized bench for dsm_dac_multi against an arithmetic model.
module tb_dsm_dac_multi;
  localparam int CH_NUM = 2;
  localparam int BW     = 10;
  localparam int FD     = 5;
  localparam int OSR    = 4;
  localparam int PERIOD = FD * OSR;
  localparam int DW     = CH_NUM * BW;

  logic              clk = 1'b0;
  logic              reset, s_valid, mute, order2, s_ready, underrun;
  logic [DW-1:0]     s_data;
  logic [CH_NUM-1:0] dac_out;
  logic [7:0]        underrun_cnt;

  always #5 clk = ~clk;

  dsm_dac_multi #(.CH_NUM(CH_NUM), .BIT_WIDTH(BW), .FREQ_DIV(FD), .OSR(OSR)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .mute(mute), .order2(order2), .dac_out(dac_out),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, kept as plain integers.
  int cyc;
  bit m_hf;
  int m_hold[CH_NUM], m_active[CH_NUM], m_acc[CH_NUM];
  bit [CH_NUM-1:0] m_dac;
  bit m_under;
  int m_ucnt;
  bit chk_dac;
  bit acc_seen;
  int ones[CH_NUM];
  int ticks, n_under;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; m_hf = 0; m_dac = '0; m_under = 0; m_ucnt = 0;
    for (int ch = 0; ch < CH_NUM; ch++) begin
      m_hold[ch] = 0; m_active[ch] = 0; m_acc[ch] = 0;
    end
  endtask

  task automatic model_step();
    bit tk, bnd, rdy, take;
    int u, s;
    tk   = ((cyc + 1) % FD) == 0;
    bnd  = tk && (((cyc + 1) % PERIOD) == 0);
    rdy  = !m_hf || bnd;
    take = s_valid && rdy;
    if (tk) begin
      for (int ch = 0; ch < CH_NUM; ch++) begin
        u = mute ? 512 : m_active[ch] + 512;
        s = m_acc[ch] + u;
        m_dac[ch] = (s >= 1024);
        m_acc[ch] = s % 1024;
      end
    end
    m_under = bnd && !m_hf;
    if (m_under && m_ucnt < 255) m_ucnt++;
    if (bnd && m_hf) m_active = m_hold;
    if (take) begin
      for (int ch = 0; ch < CH_NUM; ch++) m_hold[ch] = $signed(s_data[ch*BW +: BW]);
      m_hf = 1;
    end else if (bnd) begin
      m_hf = 0;
    end
    cyc++;
  endtask

  // One clock: check s_ready before the edge, step model, check outputs after.
  task automatic cycle();
    check("s_ready", 32'(s_ready), 32'(!m_hf || (((cyc + 1) % PERIOD) == 0)));
    acc_seen = s_valid && s_ready;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (chk_dac) check("dac_out", 32'(dac_out), 32'(m_dac));
    check("underrun", 32'(underrun), 32'(m_under));
    check("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
    if (underrun) n_under++;
    if (cyc % FD == 0) begin
      ticks++;
      for (int ch = 0; ch < CH_NUM; ch++) ones[ch] += int'(dac_out[ch]);
    end
  endtask

  task automatic run_ticks(input int n);
    ticks = 0;
    for (int ch = 0; ch < CH_NUM; ch++) ones[ch] = 0;
    for (int i = 0; i < n * FD + FD && ticks < n; i++) cycle();
    check("tick_budget", 32'(ticks), 32'(n));
  endtask

  initial begin
    int a_cyc, b_cyc, stalls, pre;
    bit b_done;
    reset = 1'b1; s_valid = 1'b0; s_data = '0; mute = 1'b0; order2 = 1'b0;
    chk_dac = 1'b1; ticks = 0; n_under = 0; a_cyc = 0; b_cyc = 0; stalls = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_dac_out", 32'(dac_out), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    reset = 1'b0;
    $display("step: reset released");

    // Zero input: first one appears on the second tick, then strict alternation.
    s_valid = 1'b1; s_data = '0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (dac_out[0]) break;
    end
    check("first_one_cyc", 32'(cyc), 32'(2 * FD));
    run_ticks(1024);
    check("zero_ones_ch0", 32'(ones[0]), 32'd512);
    check("zero_ones_ch1", 32'(ones[1]), 32'd512);
    $display("step: zero input ones ch0=%0d ch1=%0d", ones[0], ones[1]);

    // Full-scale extremes.
    s_data = {10'h200, 10'h1FF};
    repeat (3 * PERIOD) cycle();
    run_ticks(1024);
    check("max_ones_ch0", 32'(ones[0]), 32'd1023);
    check("min_ones_ch1", 32'(ones[1]), 32'd0);
    $display("step: extremes ones ch0=%0d ch1=%0d", ones[0], ones[1]);

    // Random traffic with gaps and occasional mute.
    for (int i = 0; i < 2000; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = DW'($urandom());
      mute    = ($urandom_range(0, 15) == 0);
      cycle();
    end
    mute = 1'b0;
    $display("step: random traffic done, underrun_cnt=%0d", underrun_cnt);

    // Back-to-back frames offered mid-period.
    s_valid = 1'b0;
    repeat (PERIOD) cycle();
    for (int i = 0; i < PERIOD && (cyc % PERIOD) != 5; i++) cycle();
    check("align_mid_period", 32'(cyc % PERIOD), 32'd5);
    s_valid = 1'b1; s_data = DW'($urandom());
    pre = cyc;
    cycle();
    check("frame_a_accepted", 32'(acc_seen), 32'd1);
    a_cyc = pre + 1;
    s_data = DW'($urandom());
    b_done = 1'b0;
    for (int i = 0; i < PERIOD + 2 && !b_done; i++) begin
      pre = cyc;
      cycle();
      if (acc_seen) begin b_done = 1'b1; b_cyc = pre + 1; end
      else stalls++;
    end
    check("frame_b_accepted", 32'(b_done), 32'd1);
    check("frame_b_on_boundary", 32'(b_cyc % PERIOD), 32'd0);
    check("frame_b_stalls", 32'(stalls), 32'(PERIOD - (a_cyc % PERIOD) - 1));
    s_valid = 1'b0;
    $display("step: frame A at cycle %0d, frame B at cycle %0d", a_cyc, b_cyc);

    // Starvation across 300 boundaries.
    repeat (PERIOD) cycle();
    n_under = 0;
    repeat (300 * PERIOD) cycle();
    check("underrun_pulses", 32'(n_under), 32'd300);
    check("underrun_cnt_sat", 32'(underrun_cnt), 32'd255);
    $display("step: starvation pulses=%0d cnt=%0d", n_under, underrun_cnt);

    // Reset during the second tick of a period with a frame held.
    s_valid = 1'b1; s_data = DW'($urandom());
    cycle();
    s_valid = 1'b0;
    for (int i = 0; i < PERIOD && (cyc % PERIOD) != 2 * FD - 1; i++) cycle();
    check("align_tick2", 32'(cyc % PERIOD), 32'(2 * FD - 1));
    #1 reset = 1'b1;
    #1;
    check("midrst_dac_out", 32'(dac_out), 32'd0);
    check("midrst_underrun", 32'(underrun), 32'd0);
    check("midrst_underrun_cnt", 32'(underrun_cnt), 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    s_valid = 1'b1; s_data = '0;
    run_ticks(64);
    check("post_rst_ones_ch0", 32'(ones[0]), 32'd32);
    $display("step: mid-period reset recovered, ones ch0=%0d", ones[0]);

`ifdef DSM_DAC_ORDER2_EN
    order2 = 1'b1; chk_dac = 1'b0;
    repeat (2 * PERIOD) cycle();
    run_ticks(1024);
    check("order2_ones_ch0_in_range", 32'(ones[0] >= 511 && ones[0] <= 513), 32'd1);
    check("order2_ones_ch1_in_range", 32'(ones[1] >= 511 && ones[1] <= 513), 32'd1);
    $display("step: order2 ones ch0=%0d ch1=%0d", ones[0], ones[1]);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
